// File: rtl/ram_arbiter.sv
// ram_arbiter: shares one single-port RAM between fetch and load/store requesters with registered RAM controls.
module ram_arbiter #(
  parameter int DataWidth = 32,
  parameter int AddrWidth = 32
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 i_req,
  input  logic [AddrWidth-1:0] i_addr,
  output logic                 i_ack,
  output logic [DataWidth-1:0] i_rdata,
  input  logic                 d_req,
  input  logic                 d_we,
  input  logic [AddrWidth-1:0] d_addr,
  input  logic [DataWidth-1:0] d_wdata,
  output logic                 d_ack,
  output logic [DataWidth-1:0] d_rdata,
  output logic [AddrWidth-1:0] ram_addr,
  output logic                 ram_r,
  output logic                 ram_w,
  output logic [DataWidth-1:0] ram_wdata,
  input  logic [DataWidth-1:0] ram_rdata,
  output logic                 busy
);
  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
  state_t state, next_state;
  logic grant_d, last_d, pick_d, is_store;
  // On a tie the port that did not win last time is served.
  assign pick_d   = d_req & (~i_req | ~last_d);
  assign is_store = pick_d & d_we;
  assign i_ack    = (state == RESP) & ~grant_d;
  assign d_ack    = (state == RESP) & grant_d;
  assign busy     = state != IDLE;
  always_ff @(posedge CLK or posedge RST)
    if (RST) state <= IDLE;
    else state <= next_state;
  always_comb begin
    next_state = state == IDLE   ? ((i_req | d_req) ? ACCESS : IDLE) :
                 state == ACCESS ? RESP : IDLE;
  end
  always_ff @(posedge CLK or posedge RST)
    if (RST) begin
      grant_d   <= 1'b0;
      last_d    <= 1'b0;
      ram_addr  <= '0;
      ram_r     <= 1'b0;
      ram_w     <= 1'b0;
      ram_wdata <= '0;
      i_rdata   <= '0;
      d_rdata   <= '0;
    end else if (state == IDLE && (i_req | d_req)) begin
      grant_d  <= pick_d;
      last_d   <= pick_d;
      ram_addr <= pick_d ? d_addr : i_addr;
      ram_r    <= ~is_store;
      ram_w    <= is_store;
      if (is_store) ram_wdata <= d_wdata;
    end else if (state == ACCESS) begin
      ram_r <= 1'b0;
      ram_w <= 1'b0;
      if (ram_r && grant_d) d_rdata <= ram_rdata;
      if (ram_r && !grant_d) i_rdata <= ram_rdata;
    end
endmodule

// File: tb/tb_ram_arbiter.sv
// tb_ram_arbiter: scoreboard bench for ram_arbiter with a behavioural RAM attached.
module tb_ram_arbiter;
  logic        CLK = 1'b0, RST = 1'b0;
  logic        i_req = 1'b0, d_req = 1'b0, d_we = 1'b0;
  logic [31:0] i_addr = '0, d_addr = '0, d_wdata = '0;
  logic        i_ack, d_ack, ram_r, ram_w, busy;
  logic [31:0] i_rdata, d_rdata, ram_addr, ram_wdata, ram_rdata;
  logic [31:0] mem [256];
  int passed = 0, total = 0, w_cnt = 0, ack_cnt = 0;

  typedef struct {logic is_d; logic chk; logic [31:0] data;} exp_t;
  exp_t sb[$];
  exp_t mon_e;

  ram_arbiter #(.DataWidth(32), .AddrWidth(32)) dut (
    .CLK(CLK), .RST(RST),
    .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ack(d_ack), .d_rdata(d_rdata),
    .ram_addr(ram_addr), .ram_r(ram_r), .ram_w(ram_w), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata), .busy(busy)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) if (ram_w === 1'b1) mem[ram_addr[9:2]] <= ram_wdata;
  assign ram_rdata = mem[ram_addr[9:2]];

  always @(negedge CLK) if (ram_w === 1'b1) w_cnt++;

  // Scoreboard: every ack must match the oldest outstanding expectation.
  always @(negedge CLK) begin
    if (!RST && (i_ack || d_ack)) begin
      ack_cnt++;
      total++;
      if (sb.size() == 0) $display("FAIL sb_unexpected_ack i_ack=%b d_ack=%b, none expected", i_ack, d_ack);
      else begin
        mon_e = sb.pop_front();
        if ({i_ack, d_ack} !== {~mon_e.is_d, mon_e.is_d} ||
            (mon_e.chk && (mon_e.is_d ? d_rdata : i_rdata) !== mon_e.data))
          $display("FAIL sb_ack i_ack=%b d_ack=%b i_rdata=%h d_rdata=%h, expected port_d=%b data=%h",
                   i_ack, d_ack, i_rdata, d_rdata, mon_e.is_d, mon_e.data);
        else passed++;
      end
    end
  end

  task automatic apply_reset;
    RST = 1'b1; i_req = 1'b0; d_req = 1'b0;
    repeat (2) @(posedge CLK);
    #1 RST = 1'b0;
  endtask

  // Called at posedge+1 in an IDLE cycle; returns at posedge+1 in the next IDLE cycle.
  task automatic do_req(input logic is_d, input logic we, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [31:0] exp_rd);
    logic st;
    logic [31:0] other;
    int w0;
    st = is_d & we;
    w0 = w_cnt;
    other = is_d ? i_rdata : d_rdata;
    if (is_d) begin d_req = 1'b1; d_we = we; d_addr = addr; d_wdata = wdata; end
    else begin i_req = 1'b1; i_addr = addr; end
    sb.push_back('{is_d, ~st, exp_rd});
    total++;
    if (busy !== 1'b0) $display("FAIL idle_busy busy=%b, expected 0", busy); else passed++;
    @(posedge CLK); #1;
    total++;
    if ({busy, ram_addr, ram_r, ram_w, i_ack, d_ack} !== {1'b1, addr, ~st, st, 2'b00} ||
        (st && ram_wdata !== wdata))
      $display("FAIL access busy=%b addr=%h r=%b w=%b wdata=%h acks=%b%b, expected addr=%h r=%b w=%b wdata=%h",
               busy, ram_addr, ram_r, ram_w, ram_wdata, i_ack, d_ack, addr, ~st, st, wdata);
    else passed++;
    @(posedge CLK); #1;
    total++;
    if ({busy, ram_r, ram_w, i_ack, d_ack, ram_addr} !== {1'b1, 2'b00, ~is_d, is_d, addr})
      $display("FAIL resp busy=%b r=%b w=%b i_ack=%b d_ack=%b addr=%h, expected i_ack=%b d_ack=%b addr=%h",
               busy, ram_r, ram_w, i_ack, d_ack, ram_addr, ~is_d, is_d, addr);
    else passed++;
    total++;
    if ((is_d ? i_rdata : d_rdata) !== other)
      $display("FAIL other_rdata got=%h, expected unchanged %h", is_d ? i_rdata : d_rdata, other);
    else passed++;
    total++;
    if (is_d && !we && d_rdata !== exp_rd) $display("FAIL d_rdata got=%h, expected %h", d_rdata, exp_rd);
    else passed++;
    @(posedge CLK); #1;
    i_req = 1'b0; d_req = 1'b0;
    total++;
    if ({busy, i_ack, d_ack} !== 3'b000 || w_cnt - w0 !== (st ? 1 : 0))
      $display("FAIL back_idle busy=%b acks=%b%b w_cycles=%0d, expected 0 00 %0d",
               busy, i_ack, d_ack, w_cnt - w0, st ? 1 : 0);
    else passed++;
  endtask

  task automatic test_reset;
    apply_reset();
    total++;
    if ({busy, i_ack, d_ack, ram_r, ram_w, ram_addr, ram_wdata, i_rdata, d_rdata} !== '0)
      $display("FAIL reset_outputs busy=%b acks=%b%b r=%b w=%b addr=%h wdata=%h ir=%h dr=%h, expected all 0",
               busy, i_ack, d_ack, ram_r, ram_w, ram_addr, ram_wdata, i_rdata, d_rdata);
    else passed++;
  endtask

  task automatic test_store;
    do_req(1'b1, 1'b1, 32'h10, 32'hDEADBEEF, 32'h0);
    total++;
    if (mem[4] !== 32'hDEADBEEF) $display("FAIL store_mem mem[4]=%h, expected deadbeef", mem[4]); else passed++;
  endtask

  task automatic test_load;
    do_req(1'b1, 1'b0, 32'h10, 32'h0, 32'hDEADBEEF);
    total++;
    if (i_rdata !== 32'h0) $display("FAIL load_i_rdata got=%h, expected 0", i_rdata); else passed++;
  endtask

  task automatic test_fetch;
    do_req(1'b1, 1'b1, 32'h4, 32'h00621822, 32'h0);
    do_req(1'b0, 1'b0, 32'h4, 32'h0, 32'h00621822);
    total++;
    if ({i_rdata, d_rdata} !== {32'h00621822, 32'hDEADBEEF})
      $display("FAIL fetch_rdata i=%h d=%h, expected 00621822 deadbeef", i_rdata, d_rdata);
    else passed++;
  endtask

  task automatic test_contention;
    int cyc, n;
    apply_reset();
    i_req = 1'b1; i_addr = 32'h4;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h10;
    for (int k = 0; k < 4; k++) sb.push_back('{(k % 2) == 0, 1'b1, (k % 2) == 0 ? 32'hDEADBEEF : 32'h00621822});
    cyc = 0; n = 0;
    while (n < 4 && cyc < 40) begin
      @(posedge CLK); #1;
      cyc++;
      if (i_ack || d_ack) begin
        total++;
        if (cyc !== 2 + 3 * n) $display("FAIL tie_spacing ack %0d at cycle %0d, expected %0d", n, cyc, 2 + 3 * n);
        else passed++;
        n++;
      end
    end
    i_req = 1'b0; d_req = 1'b0;
    total++;
    if (n !== 4) $display("FAIL tie_timeout acks=%0d, expected 4", n); else passed++;
    @(posedge CLK); #1;
  endtask

  task automatic test_reset_mid_access;
    int a0;
    a0 = ack_cnt;
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h20; d_wdata = 32'h12345678;
    @(posedge CLK); #1;
    total++;
    if (ram_w !== 1'b1) $display("FAIL abort_pre_w ram_w=%b, expected 1", ram_w); else passed++;
    #2 RST = 1'b1;
    #1;
    total++;
    if ({ram_w, busy} !== 2'b00) $display("FAIL abort_async ram_w=%b busy=%b, expected 0 0", ram_w, busy); else passed++;
    d_req = 1'b0;
    repeat (2) @(posedge CLK);
    #1 RST = 1'b0;
    total++;
    if ({busy, i_ack, d_ack, ram_r, ram_w, ram_addr, ram_wdata, i_rdata, d_rdata} !== '0)
      $display("FAIL abort_outputs busy=%b r=%b w=%b addr=%h wdata=%h ir=%h dr=%h, expected all 0",
               busy, ram_r, ram_w, ram_addr, ram_wdata, i_rdata, d_rdata);
    else passed++;
    repeat (3) @(posedge CLK);
    #1;
    total++;
    if (mem[8] === 32'h12345678 || ack_cnt !== a0)
      $display("FAIL abort_effect mem[8]=%h acks=%0d, expected no write and 0 acks", mem[8], ack_cnt - a0);
    else passed++;
  endtask

  task automatic test_back_to_back;
    do_req(1'b1, 1'b1, 32'h0, 32'h11111111, 32'h0);
    do_req(1'b1, 1'b1, 32'h8, 32'h33333333, 32'h0);
    do_req(1'b0, 1'b0, 32'h0, 32'h0, 32'h11111111);
    do_req(1'b0, 1'b0, 32'h4, 32'h0, 32'h00621822);
    do_req(1'b0, 1'b0, 32'h8, 32'h0, 32'h33333333);
  endtask

  initial begin
    test_reset();
    test_store();
    test_load();
    test_fetch();
    test_contention();
    test_reset_mid_access();
    test_back_to_back();
    repeat (2) @(posedge CLK);
    #1;
    total++;
    if (sb.size() !== 0) $display("FAIL sb_leftover pending=%0d, expected 0", sb.size()); else passed++;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/ram_arbiter.md
Name: ram_arbiter

Overview:
- Two-requester arbiter and sequencer for the single-port unified instruction/data RAM in the multicycle MIPS CPU.
- Shares the RAM between the instruction-fetch port (i_*) and the load/store port (d_*).
- Drives glitch-free, registered RAM address/R/W/write-data so the RAM's level-sensitive write fires exactly once per store.
- Registers read data and returns it to each requester with a one-cycle ack pulse.

Parameters:
DataWidth, 32, width of data words
AddrWidth, 32, width of byte addresses passed through to the RAM

Ports:
CLK  input  1  clock, rising edge
RST  input  1  asynchronous active-high reset
i_req  input  1  fetch request; held high until i_ack
i_addr  input  AddrWidth  fetch byte address; stable while i_req high
i_ack  output  1  one-cycle pulse: fetch complete, i_rdata valid
i_rdata  output  DataWidth  last fetched word (registered)
d_req  input  1  data request; held high until d_ack
d_we  input  1  1 = store, 0 = load; stable while d_req high
d_addr  input  AddrWidth  data byte address; stable while d_req high
d_wdata  input  DataWidth  store data; stable while d_req high
d_ack  output  1  one-cycle pulse: load/store complete
d_rdata  output  DataWidth  last loaded word (registered)
ram_addr  output  AddrWidth  RAM address (registered)
ram_r  output  1  RAM read enable (registered)
ram_w  output  1  RAM write enable (registered)
ram_wdata  output  DataWidth  RAM write data (registered)
ram_rdata  input  DataWidth  RAM read data, combinational from ram_addr
busy  output  1  high in ACCESS and RESP states

Behaviour:
- Reset (async, immediate): state IDLE; all outputs 0; last_grant = I.
  - ram_w drops without waiting for a clock edge.
  - A reset mid-ACCESS aborts the access: no ack is issued and no write completes after RST asserts.
- States:
  - IDLE -> ACCESS when i_req or d_req is high.
  - ACCESS -> RESP unconditionally.
  - RESP -> IDLE unconditionally.
- IDLE grant decision (registered on the edge leaving IDLE):
  - Only one req high: grant that port.
  - Both high: grant the port not equal to last_grant. Since last_grant resets to I, the first tie goes to D.
  - last_grant updates to the granted port.
- Entering ACCESS, the following registers load:
  - ram_addr = granted address.
  - ram_r = 1 for a fetch or load, 0 for a store.
  - ram_w = 1 only for a store (d_we = 1).
  - ram_wdata = d_wdata for a store, otherwise held.
- ACCESS lasts exactly one cycle.
- On the edge leaving ACCESS:
  - ram_r and ram_w return to 0; ram_addr and ram_wdata hold.
  - Read grant: ram_rdata is captured into the granted port's rdata register. The other port's rdata is unchanged.
  - Store: d_rdata is unchanged.
- RESP: the granted port's ack is high for exactly this cycle; the other ack stays 0.
- Latency: req first sampled high in IDLE at edge t; ack high during cycle t+2. Minimum 3 cycles per access.
- Requester rules:
  - A requester may drop req, or present a new request, from the cycle after ack.
  - A req that stays high after ack is treated as a new request in IDLE.
  - A losing requester waits, req held; it is guaranteed service on the next IDLE when it is the only port requesting or when the tie rule favours it.
- Worst-case wait under continuous contention is one access (3 cycles).
- Request deasserted before ack: protocol violation, undefined result. The arbiter still completes the latched access.
- Address handling: the arbiter does no alignment check; full addresses pass through and the RAM decodes Addr[9:2].
- ram_addr, ram_w and ram_wdata are driven from flops only (no combinational path from inputs to RAM controls).

Test Plan:
- After reset, with d_req=1, d_we=1, d_addr=0x10, d_wdata=0xDEADBEEF: ram_w=1 for exactly one cycle, ram_addr=0x10, ram_wdata=0xDEADBEEF, d_ack pulses 2 cycles after the request is sampled, mem[4]=0xDEADBEEF.
- Load readback: d_req=1, d_we=0, d_addr=0x10 -> d_rdata=0xDEADBEEF at d_ack, ram_w stays 0, i_rdata unchanged.
- Fetch: i_req=1, i_addr=0x4 with mem[1]=0x00621822 -> i_ack one cycle, i_rdata=0x00621822, d_ack stays 0.
- Simultaneous i_req and d_req held continuously for 4 grants after reset -> grant order D, I, D, I, acks alternating every 3 cycles.
- Assert RST during ACCESS of a store to 0x20 -> ram_w drops immediately, no d_ack; after release, state IDLE, all outputs 0.
- Back-to-back fetches at 0x0, 0x4, 0x8 (req held, address changed after each ack) -> three i_acks spaced 3 cycles apart, busy low only in IDLE cycles.
